data_ram_responder: RTL and testbench

Multi-cycle backing-store responder for the data-cache miss path. It accepts single-word read/write requests on the cs/wea/addra/dina bus driven by the cache controller. After a fixed, parameterised access latency it returns douta together with a one-cycle ack. It models the slow main memory behind the data cache, so the cache FSM and pipeline stall logic can be exercised against realistic latency.

---
 rtl/data_ram_pkg.sv | 16 +
 rtl/data_ram_array.sv | 38 +++
 rtl/data_ram_responder.sv | 135 +++++++++++++
 tb/tb_data_ram_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
// Shared types and defaults for the data-cache backing-store responder.
// Optional protocol checking is enabled with DATA_RAM_PROTO_CHECK_EN.
package data_ram_pkg;

    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_LATENCY = 4;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/data_ram_array.sv
// Single-port synchronous word storage with a registered, write-first read port.
// Contents are deliberately not reset; only the read register is.
module data_ram_array
    import data_ram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // The read register only moves on an access, so it holds the last result between acks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_en) begin
            r_rdata <= i_we ? i_wdata : r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_ram_responder.sv
// Fixed-latency memory responder for the data-cache miss path (IDLE/BUSY/ACK FSM).
// Define DATA_RAM_PROTO_CHECK_EN to enable the sticky proto_err request-stability check.
module data_ram_responder
    import data_ram_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              cs,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    output logic [DATA_W-1:0] douta,
    output logic              ack,
    output logic              proto_err,
    output logic [1:0]        dbg_state
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              r_ack;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              w_accept;
    logic              w_access;
    logic              w_acc_we;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [DATA_W-1:0] w_acc_data;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_accept   = 1'b0;
        w_access   = 1'b0;
        case (r_state)
            IDLE: begin
                if (cs) begin
                    w_accept   = 1'b1;
                    w_cnt_next = CNT_LOAD;
                    if (LATENCY == 1) begin
                        w_access = 1'b1;
                        w_next   = ACK;
                    end else begin
                        w_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!cs) begin
                    w_next = IDLE;
                end else if (r_cnt == '0) begin
                    w_access = 1'b1;
                    w_next   = ACK;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            ACK: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Only the single-cycle case accesses on the accept edge, before the latches are loaded.
    assign w_acc_we   = (r_state == IDLE) ? wea   : r_we;
    assign w_acc_addr = (r_state == IDLE) ? addra : r_addr;
    assign w_acc_data = (r_state == IDLE) ? dina  : r_data;

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_ack   <= (w_next == ACK);
            if (w_accept) begin
                r_we   <= wea;
                r_addr <= addra;
                r_data <= dina;
            end
        end
    end

    data_ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clka),
        .rst     (rst),
        .i_en    (w_access),
        .i_we    (w_acc_we),
        .i_addr  (w_acc_addr),
        .i_wdata (w_acc_data),
        .o_rdata (douta)
    );

`ifdef DATA_RAM_PROTO_CHECK_EN
    logic r_proto_err;
    logic w_req_changed;

    assign w_req_changed = (wea != r_we) || (addra != r_addr) || (dina != r_data);

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            r_proto_err <= 1'b0;
        end else if ((r_state == BUSY) && (!cs || w_req_changed)) begin
            r_proto_err <= 1'b1;
        end
    end

    assign proto_err = r_proto_err;
`else
    assign proto_err = 1'b0;
`endif

    assign ack       = r_ack;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_data_ram_responder.sv
// Scoreboard bench for data_ram_responder: a LATENCY=4 and a LATENCY=1 instance share clock and reset.
module tb_data_ram_responder;

    localparam int AW = 10;
    localparam int DW = 32;
`ifdef DATA_RAM_PROTO_CHECK_EN
    localparam logic PCHK = 1'b1;
`else
    localparam logic PCHK = 1'b0;
`endif

    logic clka = 1'b0;
    logic rst  = 1'b1;
    always #5 clka = ~clka;

    logic          cs4 = 1'b0, we4 = 1'b0;
    logic [AW-1:0] addr4 = '0;
    logic [DW-1:0] din4 = '0, dout4;
    logic          ack4, perr4;
    logic [1:0]    st4;

    logic          cs1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr1 = '0;
    logic [DW-1:0] din1 = '0, dout1;
    logic          ack1, perr1;
    logic [1:0]    st1;

    data_ram_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(4)) dut4 (
        .clka(clka), .rst(rst), .cs(cs4), .wea(we4), .addra(addr4), .dina(din4),
        .douta(dout4), .ack(ack4), .proto_err(perr4), .dbg_state(st4)
    );

    data_ram_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1)) dut1 (
        .clka(clka), .rst(rst), .cs(cs1), .wea(we1), .addra(addr1), .dina(din1),
        .douta(dout1), .ack(ack1), .proto_err(perr1), .dbg_state(st1)
    );

    int cyc = 0;
    always @(posedge clka) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_q4[$];
    int            exp_c4[$];
    logic [DW-1:0] exp_q1[$];
    int            exp_c1[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitors: every ack pops one expected (data, cycle) pair.
    always @(negedge clka) begin
        if (ack4 === 1'b1) begin
            if (exp_q4.size() == 0) begin
                check("ack4_unexpected", 64'(ack4), 64'd0);
            end else begin
                logic [DW-1:0] d;
                int c;
                d = exp_q4.pop_front();
                c = exp_c4.pop_front();
                check("dout4", 64'(dout4), 64'(d));
                check("ack4_cycle", 64'(cyc), 64'(c));
            end
        end
    end

    always @(negedge clka) begin
        if (ack1 === 1'b1) begin
            if (exp_q1.size() == 0) begin
                check("ack1_unexpected", 64'(ack1), 64'd0);
            end else begin
                logic [DW-1:0] d;
                int c;
                d = exp_q1.pop_front();
                c = exp_c1.pop_front();
                check("dout1", 64'(dout1), 64'(d));
                check("ack1_cycle", 64'(cyc), 64'(c));
            end
        end
    end

    task automatic wait_ack4();
        int n = 0;
        do begin
            @(negedge clka);
            n++;
        end while (ack4 !== 1'b1 && n < 40);
        if (ack4 !== 1'b1) begin
            check("ack4_timeout", 64'd0, 64'd1);
            exp_q4.delete();
            exp_c4.delete();
        end
    endtask

    task automatic wait_ack1();
        int n = 0;
        do begin
            @(negedge clka);
            n++;
        end while (ack1 !== 1'b1 && n < 40);
        if (ack1 !== 1'b1) begin
            check("ack1_timeout", 64'd0, 64'd1);
            exp_q1.delete();
            exp_c1.delete();
        end
    endtask

    // Request on the LATENCY=4 instance; cs drops in the ack cycle.
    task automatic req4(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] e);
        @(negedge clka);
        we4 = w; addr4 = a; din4 = d; cs4 = 1'b1;
        exp_q4.push_back(e);
        exp_c4.push_back(cyc + 1 + 4);
        wait_ack4();
        cs4 = 1'b0;
    endtask

    task automatic req1(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] e);
        @(negedge clka);
        we1 = w; addr1 = a; din1 = d; cs1 = 1'b1;
        exp_q1.push_back(e);
        exp_c1.push_back(cyc + 1);
        wait_ack1();
        cs1 = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clka);
        check("rst_ack4", 64'(ack4), 64'd0);
        check("rst_dout4", 64'(dout4), 64'd0);
        check("rst_perr4", 64'(perr4), 64'd0);
        check("rst_state4", 64'(st4), 64'd0);
        check("rst_ack1", 64'(ack1), 64'd0);
        rst = 1'b0;

        // Write then read with hold check.
        req4(1'b1, 10'h005, 32'hDEADBEEF, 32'hDEADBEEF);
        req4(1'b0, 10'h005, 32'h0, 32'hDEADBEEF);
        repeat (3) @(negedge clka);
        check("hold_dout4", 64'(dout4), 64'hDEADBEEF);
        check("hold_ack4", 64'(ack4), 64'd0);

        // Address extremes.
        req4(1'b1, 10'h3FF, 32'hA5A5A5A5, 32'hA5A5A5A5);
        req4(1'b1, 10'h000, 32'h5A5A5A5A, 32'h5A5A5A5A);
        req4(1'b0, 10'h3FF, 32'h0, 32'hA5A5A5A5);
        req4(1'b0, 10'h000, 32'h0, 32'h5A5A5A5A);

        // Abort: cs drops after the accept edge and one BUSY edge.
        @(negedge clka);
        we4 = 1'b1; addr4 = 10'h3FF; din4 = 32'h12345678; cs4 = 1'b1;
        repeat (2) @(negedge clka);
        cs4 = 1'b0;
        repeat (6) @(negedge clka);
        check("abort_dout4", 64'(dout4), 64'h5A5A5A5A);
        check("abort_perr4", 64'(perr4), 64'(PCHK));
        check("abort_state4", 64'(st4), 64'd0);
        req4(1'b0, 10'h3FF, 32'h0, 32'hA5A5A5A5);

        // Reset in the middle of a write.
        @(negedge clka);
        we4 = 1'b1; addr4 = 10'h3FF; din4 = 32'hBAD0BAD0; cs4 = 1'b1;
        repeat (2) @(negedge clka);
        rst = 1'b1; cs4 = 1'b0;
        #1;
        check("midrst_ack4", 64'(ack4), 64'd0);
        check("midrst_dout4", 64'(dout4), 64'd0);
        check("midrst_state4", 64'(st4), 64'd0);
        check("midrst_perr4", 64'(perr4), 64'd0);
        @(negedge clka);
        rst = 1'b0;
        req4(1'b0, 10'h3FF, 32'h0, 32'hA5A5A5A5);
        check("clean_perr4", 64'(perr4), 64'd0);

        // Address changes mid-BUSY; the access must still use the latched 0x010.
        req4(1'b1, 10'h010, 32'h11111111, 32'h11111111);
        req4(1'b1, 10'h011, 32'h22222222, 32'h22222222);
        @(negedge clka);
        we4 = 1'b1; addr4 = 10'h010; din4 = 32'h33333333; cs4 = 1'b1;
        exp_q4.push_back(32'h33333333);
        exp_c4.push_back(cyc + 1 + 4);
        @(negedge clka);
        addr4 = 10'h011;
        wait_ack4();
        cs4 = 1'b0;
        check("chg_perr4", 64'(perr4), 64'(PCHK));
        req4(1'b0, 10'h010, 32'h0, 32'h33333333);
        req4(1'b0, 10'h011, 32'h0, 32'h22222222);
        check("sticky_perr4", 64'(perr4), 64'(PCHK));

        // LATENCY=1: write, then a held read yields acks two cycles apart.
        req1(1'b1, 10'h007, 32'hCAFEF00D, 32'hCAFEF00D);
        @(negedge clka);
        we1 = 1'b0; addr1 = 10'h007; din1 = 32'h0; cs1 = 1'b1;
        exp_q1.push_back(32'hCAFEF00D);
        exp_c1.push_back(cyc + 1);
        exp_q1.push_back(32'hCAFEF00D);
        exp_c1.push_back(cyc + 3);
        wait_ack1();
        wait_ack1();
        cs1 = 1'b0;
        check("perr1", 64'(perr1), 64'd0);

        repeat (6) @(negedge clka);
        check("q4_drained", 64'(exp_q4.size()), 64'd0);
        check("q1_drained", 64'(exp_q1.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
